// File: rtl/td4_pkg.sv
// Shared TD4 opcode encodings and instruction field widths.
package td4_pkg;
    localparam int OPW = 4;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_ADD_A  = 4'b0000;
    localparam opcode_t OP_MOV_AB = 4'b0001;
    localparam opcode_t OP_IN_A   = 4'b0010;
    localparam opcode_t OP_MOV_AI = 4'b0011;
    localparam opcode_t OP_MOV_BA = 4'b0100;
    localparam opcode_t OP_ADD_B  = 4'b0101;
    localparam opcode_t OP_IN_B   = 4'b0110;
    localparam opcode_t OP_MOV_BI = 4'b0111;
    localparam opcode_t OP_OUT_B  = 4'b1001;
    localparam opcode_t OP_OUT_I  = 4'b1011;
    localparam opcode_t OP_JNC    = 4'b1110;
    localparam opcode_t OP_JMP    = 4'b1111;
endpackage

// File: rtl/td4_if.sv
// Program ROM bus: the core drives the address, the ROM answers combinationally.
interface td4_if
    import td4_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4
);
    logic [AW-1:0]     adr;
    logic [OPW+DW-1:0] instr;

    modport master (output adr, input instr);
    modport slave  (input adr, output instr);
endinterface

// File: rtl/td4_alu.sv
// DW-bit adder; the carry out becomes the TD4 carry flag.
module td4_alu #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/td4_core.sv
// TD4 core: single-cycle fetch/execute of the 12-instruction ISA with stall enable.
module td4_core
    import td4_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    td4_if.master         rom,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic          out_we,
    output logic          carry,
    output logic [DW-1:0] reg_a,
    output logic [DW-1:0] reg_b
);
    generate
        if ((AW < 1) || (AW > DW)) begin : g_bad_param
            $fatal(1, "td4_core: AW must satisfy 1 <= AW <= DW");
        end
    endgenerate

    opcode_t       opcode;
    logic [DW-1:0] imm;
    logic [DW-1:0] src;
    logic [DW-1:0] res;
    logic          co;
    logic [AW-1:0] pc;

    assign opcode  = rom.instr[DW+OPW-1:DW];
    assign imm     = rom.instr[DW-1:0];
    assign rom.adr = pc;

    always_comb begin
        src = '0;
        case (opcode)
            OP_ADD_A, OP_MOV_BA:           src = reg_a;
            OP_ADD_B, OP_MOV_AB, OP_OUT_B: src = reg_b;
            OP_IN_A, OP_IN_B:              src = in_port;
            default:                       src = '0;
        endcase
    end

    td4_alu #(.DW(DW)) u_alu (
        .a   (src),
        .b   (imm),
        .sum (res),
        .co  (co)
    );

    // Every writing instruction takes the adder result; immediates ride through with src=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a    <= '0;
            reg_b    <= '0;
            pc       <= '0;
            carry    <= 1'b0;
            out_port <= '0;
            out_we   <= 1'b0;
        end else if (en) begin
            carry  <= co;
            out_we <= 1'b0;
            pc     <= pc + AW'(1);
            case (opcode)
                OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: reg_a <= res;
                OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: reg_b <= res;
                OP_OUT_B, OP_OUT_I: begin
                    out_port <= res;
                    out_we   <= 1'b1;
                end
                OP_JNC: if (!carry) pc <= imm[AW-1:0];
                OP_JMP: pc <= imm[AW-1:0];
                default: ;
            endcase
        end else begin
            out_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core at DW=4/AW=4 and DW=8/AW=6 with a queued scoreboard.
module tb_td4_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, reset1, en1;
    logic [3:0] in_port;
    logic [7:0] in_port1;
    logic [3:0] out0, a0, b0;
    logic       we0, c0;
    logic [7:0] out1, a1, b1;
    logic       we1, c1;

    logic [7:0]  rom0 [16];
    logic [11:0] rom1 [64];

    td4_if #(.DW(4), .AW(4)) bus0 ();
    td4_if #(.DW(8), .AW(6)) bus1 ();
    assign bus0.instr = rom0[bus0.adr];
    assign bus1.instr = rom1[bus1.adr];

    td4_core #(.DW(4), .AW(4)) dut (
        .clk(clk), .reset(reset), .en(en), .rom(bus0), .in_port(in_port),
        .out_port(out0), .out_we(we0), .carry(c0), .reg_a(a0), .reg_b(b0)
    );

    td4_core #(.DW(8), .AW(6)) dut1 (
        .clk(clk), .reset(reset1), .en(en1), .rom(bus1), .in_port(in_port1),
        .out_port(out1), .out_we(we1), .carry(c1), .reg_a(a1), .reg_b(b1)
    );

    typedef struct {
        string tag;
        bit    d;
        int    a, b, c, adr, out, we;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input int exp);
        if (exp < 0) return;
        tests++;
        assert (obs === 32'(exp)) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp0(input string tag, input int a, b, c, adr, out, we);
        exp_t e;
        e.tag = tag; e.d = 1'b0;
        e.a = a; e.b = b; e.c = c; e.adr = adr; e.out = out; e.we = we;
        sb.push_back(e);
    endtask

    task automatic exp1(input string tag, input int a, c, adr);
        exp_t e;
        e.tag = tag; e.d = 1'b1;
        e.a = a; e.b = -1; e.c = c; e.adr = adr; e.out = -1; e.we = -1;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.d) begin
                cmp({e.tag, ".a"},   32'(a0),       e.a);
                cmp({e.tag, ".b"},   32'(b0),       e.b);
                cmp({e.tag, ".c"},   32'(c0),       e.c);
                cmp({e.tag, ".adr"}, 32'(bus0.adr), e.adr);
                cmp({e.tag, ".out"}, 32'(out0),     e.out);
                cmp({e.tag, ".we"},  32'(we0),      e.we);
            end else begin
                cmp({e.tag, ".a"},   32'(a1),       e.a);
                cmp({e.tag, ".c"},   32'(c1),       e.c);
                cmp({e.tag, ".adr"}, 32'(bus1.adr), e.adr);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic fill0(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom0[i] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1; reset1 = 1'b1; en1 = 1'b0;
        in_port = 4'd0; in_port1 = 8'd0;
        fill0(8'h00);
        for (int i = 0; i < 64; i++) rom1[i] = 12'h800;

        // reset, then ADD B,2
        exp0("reset", 0, 0, 0, 0, 0, 0); tick();
        rom0[0] = 8'h52; reset = 1'b0;
        exp0("addb", 0, 2, 0, 1, 0, 0); tick();

        // MOV A,1; ADD A,15; JNC 5; JNC 5; JMP 5
        fill0(8'h80);
        rom0[0] = 8'h31; rom0[1] = 8'h0F; rom0[2] = 8'hE5; rom0[3] = 8'hE5; rom0[5] = 8'hF5;
        reset = 1'b1;
        exp0("rst2", 0, 0, 0, 0, 0, 0); tick();
        reset = 1'b0;
        exp0("mova",     1, 0, 0, 1, 0, 0); tick();
        exp0("adda_ovf", 0, 0, 1, 2, 0, 0); tick();
        exp0("jnc_fall", 0, 0, 0, 3, 0, 0); tick();
        exp0("jnc_take", 0, 0, 0, 5, 0, 0); tick();
        exp0("halt5",    0, 0, 0, 5, 0, 0); tick();

        // IN A; MOV B,A; OUT B; OUT 0xA; JMP 4
        fill0(8'h80);
        rom0[0] = 8'h20; rom0[1] = 8'h40; rom0[2] = 8'h90; rom0[3] = 8'hBA; rom0[4] = 8'hF4;
        in_port = 4'd7; reset = 1'b1;
        exp0("rst3", 0, 0, 0, 0, 0, 0); tick();
        reset = 1'b0;
        exp0("in_a",  7, 0, 0, 1, 0, 0);  tick();
        exp0("movba", 7, 7, 0, 2, 0, 0);  tick();
        exp0("outb",  7, 7, 0, 3, 7, 1);  tick();
        exp0("outi",  7, 7, 0, 4, 10, 1); tick();
        exp0("we_lo", 7, 7, 0, 4, 10, 0); tick();

        // stall in the middle of the same program, then a mid-cycle reset
        reset = 1'b1;
        exp0("rst4", 0, 0, 0, 0, 0, 0); tick();
        reset = 1'b0;
        tick(); tick();
        exp0("pre_stall", 7, 7, 0, 3, 7, 1); tick();
        en = 1'b0;
        in_port = 4'd3;
        for (int i = 0; i < 5; i++) begin
            exp0("stall", 7, 7, 0, 3, 7, 0); tick();
        end
        en = 1'b1;
        exp0("resume", 7, 7, 0, 4, 10, 1); tick();
        #2 reset = 1'b1;
        #1;
        exp0("rst_mid_hold", 7, 7, 0, 4, 10, 1); drain();
        exp0("rst_mid_edge", 0, 0, 0, 0, 0, 0);  tick();
        reset = 1'b0;

        // 16 NOPs wrap the PC, then JMP 3 and halt at 3
        fill0(8'h80);
        for (int i = 1; i <= 16; i++) begin
            if (i == 15)      exp0("nop15", 0, 0, 0, 15, 0, 0);
            else if (i == 16) exp0("wrap",  0, 0, 0, 0, 0, 0);
            tick();
        end
        rom0[0] = 8'hF3; rom0[3] = 8'hF3;
        exp0("jmp3", 0, 0, 0, 3, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            exp0("halt3", -1, -1, 0, 3, -1, 0); tick();
        end

        // DW=8, AW=6: carry out of bit 7 and jump target truncation
        rom1[0] = 12'h301; rom1[1] = 12'h0FF; rom1[2] = 12'hFC5; rom1[5] = 12'hF05;
        exp1("w_rst", 0, 0, 0); tick();
        reset1 = 1'b0; en1 = 1'b1;
        exp1("w_mova", 1, 0, 1);    tick();
        exp1("w_ovf",  0, 1, 2);    tick();
        exp1("w_jmp",  0, 0, 5);    tick();
        exp1("w_halt", 0, 0, 5);    tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
